// File: rtl/price_frame_if.sv
// Byte-in / price-out bundle between the UART receiver, the frame decoder and strategy.
// Latency: none (wires only).
// Backpressure: none; rx_valid is a one-cycle strobe and the sink must always accept.
interface price_frame_if #(
    parameter int ERR_CNT_W = 8
) ();
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [15:0]          price_A;
    logic [15:0]          price_B;
    logic                 packet_valid;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;

    // Byte source side: drives received bytes, observes decoded prices and errors.
    modport master (
        output rx_data, rx_valid,
        input  price_A, price_B, packet_valid, frame_err, err_count
    );

    // Decoder side.
    modport slave (
        input  rx_data, rx_valid,
        output price_A, price_B, packet_valid, frame_err, err_count
    );
endinterface

// File: rtl/price_frame_decoder.sv
// Assembles HEADER,A_hi,A_lo,B_hi,B_lo,[CHK],FOOTER frames into price_A/price_B; rejects, flags and counts bad frames.
// Latency: 1 clk from the footer byte to packet_valid, and from the offending byte/timeout to frame_err.
// Backpressure: none; every rx_valid byte is consumed. Optional checksum byte enabled by CHECKSUM_EN.
module price_frame_decoder #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter logic [7:0] FOOTER      = 8'h55,
    parameter int         GAP_TIMEOUT = 50000,
    parameter int         ERR_CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    price_frame_if.slave bus
);
    localparam int             GAP_W    = $clog2(GAP_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_HI,
        S_A_LO,
        S_B_HI,
        S_B_LO,
`ifdef CHECKSUM_EN
        S_CHK,
`endif
        S_FTR
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_a_hi, r_a_lo, r_b_hi, r_b_lo;
    logic [GAP_W-1:0]     r_gap;
    logic [15:0]          r_price_a, r_price_b;
    logic                 r_pkt_vld, r_frame_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_accept, w_error, w_timeout;
`ifdef CHECKSUM_EN
    logic [7:0]           w_chk;

    assign w_chk = r_a_hi ^ r_a_lo ^ r_b_hi ^ r_b_lo;
`endif

    // A byte arriving in the timeout cycle beats the timeout.
    assign w_timeout = (r_state != S_IDLE) && !bus.rx_valid && (r_gap == GAP_LAST);

    // Frame state register; reset mid-frame simply drops back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state and accept/reject decisions; advances only on rx_valid.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_error  = 1'b0;
        if (w_timeout) begin
            w_error = 1'b1;
            w_next  = S_IDLE;
        end else if (bus.rx_valid) begin
            case (r_state)
                S_IDLE: if (bus.rx_data == HEADER) w_next = S_A_HI;
                S_A_HI: w_next = S_A_LO;
                S_A_LO: w_next = S_B_HI;
                S_B_HI: w_next = S_B_LO;
`ifdef CHECKSUM_EN
                S_B_LO: w_next = S_CHK;
                S_CHK: begin
                    if (bus.rx_data == w_chk) begin
                        w_next = S_FTR;
                    end else begin
                        w_error = 1'b1;
                        w_next  = S_IDLE;
                    end
                end
`else
                S_B_LO: w_next = S_FTR;
`endif
                S_FTR: begin
                    w_next = S_IDLE;
                    if (bus.rx_data == FOOTER) w_accept = 1'b1;
                    else                       w_error  = 1'b1;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Shadow payload, gap timer, output prices, strobes and saturating error count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_hi      <= '0;
            r_a_lo      <= '0;
            r_b_hi      <= '0;
            r_b_lo      <= '0;
            r_gap       <= '0;
            r_price_a   <= '0;
            r_price_b   <= '0;
            r_pkt_vld   <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (bus.rx_valid) begin
                case (r_state)
                    S_A_HI:  r_a_hi <= bus.rx_data;
                    S_A_LO:  r_a_lo <= bus.rx_data;
                    S_B_HI:  r_b_hi <= bus.rx_data;
                    S_B_LO:  r_b_lo <= bus.rx_data;
                    default: ;
                endcase
            end
            if (bus.rx_valid || r_state == S_IDLE || w_timeout) r_gap <= '0;
            else                                                r_gap <= r_gap + 1'b1;
            r_pkt_vld   <= w_accept;
            r_frame_err <= w_error;
            if (w_accept) begin
                r_price_a <= {r_a_hi, r_a_lo};
                r_price_b <= {r_b_hi, r_b_lo};
            end
            if (w_error && (r_err_cnt != {ERR_CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.price_A      = r_price_a;
    assign bus.price_B      = r_price_b;
    assign bus.packet_valid = r_pkt_vld;
    assign bus.frame_err    = r_frame_err;
    assign bus.err_count    = r_err_cnt;
endmodule
